// File: rtl/gps_emu_sched.sv
// gps_emu_sched: run/configuration scheduler for the in-FPGA GPS emulator.
// Host writes land in a shadow bank; the shadow bank is copied to the active
// bank on run entry or on a C/A epoch boundary with a commit pending, so that
// no satellite changes mid-code-period. On every other epoch each active
// Doppler word is advanced by its per-epoch rate (modulo 2^32).
module gps_emu_sched #(
  parameter int Nsat         = 4,
  parameter int EPOCH_CYCLES = 102300
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 run,
  input  logic                 wr_en,
  input  logic [7:0]           wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 commit_req,
  output logic                 commit_pending,
  output logic                 enable,
  output logic [32*Nsat-1:0]   freq,
  output logic [16*Nsat-1:0]   gain,
  output logic [6*Nsat-1:0]    ca_sel,
  output logic [15:0]          noise_gain,
  output logic                 epoch,
  output logic [31:0]          epoch_count
);

  localparam int                CNT_W    = (EPOCH_CYCLES > 1) ? $clog2(EPOCH_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(EPOCH_CYCLES - 1);
  localparam logic [7:0]        NOISE_ADDR = 8'hFF;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       epoch_count_q, epoch_count_d;
  logic              epoch_q, epoch_d;
  logic              commit_pending_q, commit_pending_d;
  // load_active: full shadow->active copy on this edge
  // step_active: advance every active freq by its rate on this edge
  logic              load_active;
  logic              step_active;

  logic [15:0]       sh_noise_q, sh_noise_d;
  logic [15:0]       act_noise_q, act_noise_d;

  // Next-state, epoch counter and commit bookkeeping.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    epoch_count_d    = epoch_count_q;
    epoch_d          = 1'b0;
    load_active      = 1'b0;
    step_active      = 1'b0;
    commit_pending_d = commit_pending_q | commit_req;
    case (state_q)
      S_IDLE: begin
        cnt_d         = '0;
        epoch_count_d = '0;
        if (run) begin
          state_d     = S_RUN;
          load_active = 1'b1;
        end
      end
      S_RUN: begin
        if (!run) begin
          // Stopping wins over an epoch falling on the same edge; the
          // counters restart from enable anyway.
          state_d       = S_IDLE;
          cnt_d         = '0;
          epoch_count_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d         = '0;
          epoch_d       = 1'b1;
          epoch_count_d = epoch_count_q + 32'd1;
          if (commit_pending_q) begin
            load_active = 1'b1;
          end else begin
            step_active = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A request arriving on the applying edge starts a fresh pending commit.
    if (load_active) begin
      commit_pending_d = commit_req;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      epoch_count_q    <= '0;
      epoch_q          <= 1'b0;
      commit_pending_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      epoch_count_q    <= epoch_count_d;
      epoch_q          <= epoch_d;
      commit_pending_q <= commit_pending_d;
    end
  end

  // Shadow and active noise gain (a rate step leaves it unchanged).
  always_comb begin
    sh_noise_d  = sh_noise_q;
    act_noise_d = act_noise_q;
    if (wr_en && (wr_addr == NOISE_ADDR)) begin
      sh_noise_d = wr_data[15:0];
    end
    if (load_active) begin
      act_noise_d = sh_noise_q;
    end
  end

  // Noise gain registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_noise_q  <= '0;
      act_noise_q <= '0;
    end else begin
      sh_noise_q  <= sh_noise_d;
      act_noise_q <= act_noise_d;
    end
  end

  // Per-satellite shadow and active banks.
  for (genvar gi = 0; gi < Nsat; gi++) begin : g_sat
    localparam logic [5:0] CA_RST = 6'(gi % 36);

    logic        wr_hit;
    logic [31:0] sh_freq_q,  sh_freq_d;
    logic [15:0] sh_gain_q,  sh_gain_d;
    logic [5:0]  sh_ca_q,    sh_ca_d;
    logic [31:0] sh_rate_q,  sh_rate_d;
    logic [31:0] act_freq_q, act_freq_d;
    logic [15:0] act_gain_q, act_gain_d;
    logic [5:0]  act_ca_q,   act_ca_d;
    logic [31:0] act_rate_q, act_rate_d;

    // Address 0xFF decodes to index 63, which never matches a channel.
    assign wr_hit = wr_en && (wr_addr[7:2] == 6'(gi));

    // Shadow field update; out-of-range C/A selects are dropped.
    always_comb begin
      sh_freq_d = sh_freq_q;
      sh_gain_d = sh_gain_q;
      sh_ca_d   = sh_ca_q;
      sh_rate_d = sh_rate_q;
      if (wr_hit) begin
        case (wr_addr[1:0])
          2'd0: sh_freq_d = wr_data;
          2'd1: sh_gain_d = wr_data[15:0];
          2'd2: if (wr_data <= 32'd35) sh_ca_d = wr_data[5:0];
          default: sh_rate_d = wr_data;
        endcase
      end
    end

    // Active bank: atomic copy from the pre-write shadow, or a Doppler step.
    always_comb begin
      act_freq_d = act_freq_q;
      act_gain_d = act_gain_q;
      act_ca_d   = act_ca_q;
      act_rate_d = act_rate_q;
      if (load_active) begin
        act_freq_d = sh_freq_q;
        act_gain_d = sh_gain_q;
        act_ca_d   = sh_ca_q;
        act_rate_d = sh_rate_q;
      end else if (step_active) begin
        act_freq_d = act_freq_q + act_rate_q;
      end
    end

    // Channel registers.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sh_freq_q  <= '0;
        sh_gain_q  <= '0;
        sh_ca_q    <= CA_RST;
        sh_rate_q  <= '0;
        act_freq_q <= '0;
        act_gain_q <= '0;
        act_ca_q   <= CA_RST;
        act_rate_q <= '0;
      end else begin
        sh_freq_q  <= sh_freq_d;
        sh_gain_q  <= sh_gain_d;
        sh_ca_q    <= sh_ca_d;
        sh_rate_q  <= sh_rate_d;
        act_freq_q <= act_freq_d;
        act_gain_q <= act_gain_d;
        act_ca_q   <= act_ca_d;
        act_rate_q <= act_rate_d;
      end
    end

    assign freq[32*gi +: 32]  = act_freq_q;
    assign gain[16*gi +: 16]  = act_gain_q;
    assign ca_sel[6*gi +: 6]  = act_ca_q;
  end

  assign enable         = (state_q == S_RUN);
  assign epoch          = epoch_q;
  assign epoch_count    = epoch_count_q;
  assign commit_pending = commit_pending_q;
  assign noise_gain     = act_noise_q;

endmodule

// File: doc/gps_emu_sched.md
# gps_emu_sched

Run/configuration scheduler for the in-FPGA GPS emulator. It owns the emulator `enable` and per-satellite `freq`/`gain`/`ca_sel` and `noise_gain` inputs, and holds host-written values in a shadow bank. It applies them atomically on 1 ms C/A code-epoch boundaries, so no satellite changes mid-code-period. Between commits it advances each satellite's Doppler word by a programmed per-epoch rate, producing linear Doppler ramps.

## Interface
Parameters:
- `Nsat`, 4: number of satellite channels driven; legal range 1..63.
- `EPOCH_CYCLES`, 102300: clk cycles per C/A epoch (1023 chips × 100 clk at 102.3 MHz).

Ports:
- `clk`  in  1  system clock, 102.3 MHz
- `rstn`  in  1  asynchronous, active-low reset
- `run`  in  1  level; 1 = emulation running
- `wr_en`  in  1  shadow write strobe
- `wr_addr`  in  8  [7:2] = satellite index, [1:0] = register select (0 freq, 1 gain, 2 ca_sel, 3 rate); address 0xFF = noise_gain
- `wr_data`  in  32  write data (LSBs used for narrower fields)
- `commit_req`  in  1  single-cycle pulse requesting shadow→active transfer
- `commit_pending`  out  1  commit requested, not yet applied
- `enable`  out  1  emulator enable
- `freq`  out  32×Nsat  active Doppler words
- `gain`  out  16×Nsat  active gains
- `ca_sel`  out  6×Nsat  active C/A selects
- `noise_gain`  out  16  active noise gain
- `epoch`  out  1  one-cycle pulse, first cycle of each new epoch
- `epoch_count`  out  32  epochs elapsed since `enable` rose

## Operation
- Shadow bank per satellite: freq(32), gain(16), ca_sel(6), rate(32 signed); plus a shadow noise_gain(16). Active bank drives outputs; rate is held active internally.
- Writes: any state. `wr_en` updates the addressed shadow field on the next edge. Ignored writes:
  - satellite index ≥ Nsat (except 0xFF);
  - ca_sel data > 35.
- Writes never touch the active bank directly.
- FSM states:
  - IDLE: `enable`=0, epoch counter held at 0, `epoch_count`=0. Transition: `run`=1 → RUN. On that edge, shadow→active copy and `commit_pending` cleared.
  - RUN: `enable`=1; cycle counter `cnt` runs 0..EPOCH_CYCLES-1 and wraps. Transition: `run`=0 → IDLE. Active values are retained; `cnt` and `epoch_count` are cleared.
- `commit_req` sets `commit_pending` in any state. Repeated requests while pending are no-ops. Shadow writes while pending are included in the eventual commit (latest wins).
- Epoch edge: the edge where `cnt`==EPOCH_CYCLES-1 in RUN.
  - `epoch`<=1 and `epoch_count`+=1 (wraps modulo 2^32).
  - If `commit_pending`: full shadow→active copy, `commit_pending`<=0, and no rate step this epoch.
  - Otherwise: each freq[i] <= freq[i] + rate[i], modulo 2^32 (two's-complement wrap, no saturation). gain, ca_sel and noise_gain are unchanged.
- A `commit_req` on the epoch edge itself is not applied at that edge; it is applied at the next epoch.
- Simultaneous `wr_en` to a field and commit on the same edge: the commit copies the pre-write shadow value.

## Timing
- Reset (async assert, sync release) values:
  - `enable`=0, `epoch`=0, `epoch_count`=0, `commit_pending`=0;
  - active and shadow freq, gain, rate and noise_gain = 0;
  - ca_sel[i] = i mod 36 in both banks.
- `run` rise sampled at edge N: `enable`=1 and active values are valid from N+1. `cnt`=0 at N+1.
- Epochs: the first `epoch` pulse occurs EPOCH_CYCLES cycles after `enable` rises, then one every EPOCH_CYCLES. Updated outputs appear in the same cycle as the `epoch` pulse. This alignment matches the emulator's C/A address wrap, since both restart from enable.
- `commit_pending` rises one cycle after `commit_req` and falls in the `epoch` cycle that applies it.
- `run` fall at edge M: `enable`=0 from M+1. A pending commit stays pending and is applied at the next RUN entry.
- Reset mid-RUN: all outputs return to reset values immediately (asynchronously).

## Test plan
- Reset, write sat0 freq=0x1000 and gain=0x4000, raise `run` → at cycle 1, `enable`=1, freq[0]=0x1000, gain[0]=0x4000; first `epoch` exactly 102300 cycles later; `epoch_count`=1.
- rate[1]=-5, freq[1]=3, run 3 epochs → freq[1] = 3, 0xFFFFFFFE, 0xFFFFFFF9, 0xFFFFFFF4 (wraps).
- In RUN, write gain[2]=0x7FFF and pulse `commit_req` at `cnt`=500 → `commit_pending`=1 from next cycle; gain[2] changes only at the `epoch` cycle; rate step is skipped for all satellites that epoch.
- `commit_req` on the epoch edge → not applied there; applied at the following epoch.
- Write ca_sel=40 to sat0 and write to satellite index 5 with Nsat=4, then commit → both ignored; ca_sel[0] stays 0, no other output changes.
- Drop `run` at `cnt`=1000 with a commit pending, re-raise 10 cycles later → `enable` low for 10 cycles, `epoch_count` restarts at 0, commit applied on re-entry, `commit_pending`=0.
